// File: rtl/prism_sit_load_ctrl.sv
// prism_sit_load_ctrl
// Streams configuration words from a valid/ready source onto the SIT latch
// bus. One load sequence writes DEPTH entries of WPE 32-bit words each. Every
// word gets a one-cycle latch_wr strobe followed by WR_GAP idle cycles.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a full load sequence (ignored while busy)
//   abort             cancel a sequence in progress (no effect when idle)
//   s_valid/s_data    source word handshake, s_ready high only while waiting
//   latch_data        word presented to the SIT latch bus
//   latch_wr          one-cycle latch write strobe
//   busy              sequence in progress
//   done / aborted    one-cycle completion / cancellation pulses
//   entry_idx         entry currently being loaded
//   word_idx          word within the current entry (0..WPE-1)
module prism_sit_load_ctrl #(
  parameter int WIDTH  = 80,
  parameter int DEPTH  = 2,
  parameter int WR_GAP = 1,
  localparam int WPE    = (WIDTH + 31) / 32,
  localparam int A_BITS = (DEPTH <= 2)  ? 1 :
                          (DEPTH <= 4)  ? 2 :
                          (DEPTH <= 8)  ? 3 :
                          (DEPTH <= 16) ? 4 :
                          (DEPTH <= 32) ? 5 : 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic [31:0]       latch_data,
  output logic              latch_wr,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [A_BITS-1:0] entry_idx,
  output logic [1:0]        word_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Gap counter is loaded with WR_GAP-1 on leaving WRITE and counts down to
  // zero, so GAP lasts exactly WR_GAP cycles.
  localparam logic [3:0]        GAP_LOAD   = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;
  localparam logic [1:0]        LAST_WORD  = 2'(WPE - 1);
  localparam logic [A_BITS-1:0] LAST_ENTRY = A_BITS'(DEPTH - 1);

  state_t              state_reg, state_next;
  logic [31:0]         latch_data_reg, latch_data_next;
  logic [A_BITS-1:0]   entry_idx_reg, entry_idx_next;
  logic [1:0]          word_idx_reg, word_idx_next;
  logic [3:0]          gap_cnt_reg, gap_cnt_next;
  logic                aborted_reg, aborted_next;

  // Outcome of finishing a word (after its gap): either the sequence is
  // complete or the word/entry counters advance and we wait for the next word.
  state_t              post_state;
  logic [A_BITS-1:0]   post_entry;
  logic [1:0]          post_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      latch_data_reg <= '0;
      entry_idx_reg  <= '0;
      word_idx_reg   <= '0;
      gap_cnt_reg    <= '0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      latch_data_reg <= latch_data_next;
      entry_idx_reg  <= entry_idx_next;
      word_idx_reg   <= word_idx_next;
      gap_cnt_reg    <= gap_cnt_next;
      aborted_reg    <= aborted_next;
    end
  end

  always_comb begin
    post_state = S_WAIT;
    post_entry = entry_idx_reg;
    post_word  = word_idx_reg;
    if (word_idx_reg == LAST_WORD && entry_idx_reg == LAST_ENTRY) begin
      post_state = S_DONE;
    end else if (word_idx_reg == LAST_WORD) begin
      post_word  = 2'd0;
      post_entry = entry_idx_reg + 1'b1;
    end else begin
      post_word  = word_idx_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    latch_data_next = latch_data_reg;
    entry_idx_next  = entry_idx_reg;
    word_idx_next   = word_idx_reg;
    gap_cnt_next    = gap_cnt_reg;
    aborted_next    = 1'b0;

    s_ready  = (state_reg == S_WAIT);
    latch_wr = (state_reg == S_WRITE);
    busy     = (state_reg != S_IDLE);
    done     = (state_reg == S_DONE);

    case (state_reg)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          state_next     = S_WAIT;
          entry_idx_next = '0;
          word_idx_next  = 2'd0;
          gap_cnt_next   = 4'd0;
        end
      end
      S_WAIT: begin
        if (s_valid) begin
          latch_data_next = s_data;
          state_next      = S_WRITE;
        end
      end
      S_WRITE: begin
        if (WR_GAP > 0) begin
          state_next   = S_GAP;
          gap_cnt_next = GAP_LOAD;
        end else begin
          state_next     = post_state;
          entry_idx_next = post_entry;
          word_idx_next  = post_word;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == 4'd0) begin
          state_next     = post_state;
          entry_idx_next = post_entry;
          word_idx_next  = post_word;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE: nothing is latched or advanced,
    // and a strobe already on the bus this cycle simply finishes.
    if (abort && state_reg != S_IDLE) begin
      state_next      = S_IDLE;
      latch_data_next = latch_data_reg;
      entry_idx_next  = entry_idx_reg;
      word_idx_next   = word_idx_reg;
      gap_cnt_next    = 4'd0;
      aborted_next    = 1'b1;
    end
  end

  assign latch_data = latch_data_reg;
  assign entry_idx  = entry_idx_reg;
  assign word_idx   = word_idx_reg;
  assign aborted    = aborted_reg;

endmodule

// File: tb/tb_prism_sit_load_ctrl.sv
// Testbench for prism_sit_load_ctrl. Two instances share one stimulus set:
// dut_a uses the default WR_GAP=1, dut_b uses WR_GAP=0. sel picks which one
// receives start/abort and which one is observed; the other stays idle.
module tb_prism_sit_load_ctrl;

  localparam int WPE   = 3;
  localparam int TOTAL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, s_valid;
  logic [31:0] s_data;
  logic        sel;

  logic        start_a, abort_a, start_b, abort_b;
  logic        s_ready_a, latch_wr_a, busy_a, done_a, aborted_a;
  logic        s_ready_b, latch_wr_b, busy_b, done_b, aborted_b;
  logic [31:0] latch_data_a, latch_data_b;
  logic [0:0]  entry_idx_a, entry_idx_b;
  logic [1:0]  word_idx_a, word_idx_b;

  logic        o_s_ready, o_latch_wr, o_busy, o_done, o_aborted;
  logic [31:0] o_latch_data;
  logic [0:0]  o_entry_idx;
  logic [1:0]  o_word_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_gap;
  logic [31:0] src [TOTAL];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign abort_a = abort & ~sel;
  assign start_b = start & sel;
  assign abort_b = abort & sel;

  prism_sit_load_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .latch_data(latch_data_a), .latch_wr(latch_wr_a), .busy(busy_a),
    .done(done_a), .aborted(aborted_a), .entry_idx(entry_idx_a),
    .word_idx(word_idx_a)
  );

  prism_sit_load_ctrl #(.WR_GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .latch_data(latch_data_b), .latch_wr(latch_wr_b), .busy(busy_b),
    .done(done_b), .aborted(aborted_b), .entry_idx(entry_idx_b),
    .word_idx(word_idx_b)
  );

  always_comb begin
    if (sel) begin
      o_s_ready = s_ready_b; o_latch_wr = latch_wr_b; o_busy = busy_b;
      o_done = done_b; o_aborted = aborted_b; o_latch_data = latch_data_b;
      o_entry_idx = entry_idx_b; o_word_idx = word_idx_b;
    end else begin
      o_s_ready = s_ready_a; o_latch_wr = latch_wr_a; o_busy = busy_a;
      o_done = done_a; o_aborted = aborted_a; o_latch_data = latch_data_a;
      o_entry_idx = entry_idx_a; o_word_idx = word_idx_a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_latch_wr"},   32'(o_latch_wr), 32'd0);
    check({tag, "_busy"},       32'(o_busy), 32'd0);
    check({tag, "_s_ready"},    32'(o_s_ready), 32'd0);
    check({tag, "_done"},       32'(o_done), 32'd0);
    check({tag, "_aborted"},    32'(o_aborted), 32'd0);
    check({tag, "_latch_data"}, o_latch_data, 32'd0);
    check({tag, "_entry_idx"},  32'(o_entry_idx), 32'd0);
    check({tag, "_word_idx"},   32'(o_word_idx), 32'd0);
  endtask

  // One load sequence against the reference: the k-th strobe must carry the
  // k-th word the source handed over, at entry k/WPE word k%WPE.
  // valid_pct: chance s_valid is high per cycle; abort_after: abort in the
  // cycle after that many strobes (0 = never); exact: s_valid always high so
  // strobe spacing is exactly 2+gap; rand_start: pulse start while busy.
  task automatic run_seq(input string name, input int valid_pct, input int abort_after,
                         input bit exact, input bit rand_start);
    int pulses = 0, idx = 0, last_pulse = 0, abort_cyc = -10;
    bit fin = 1'b0, abort_sent = 1'b0;
    for (int cyc = 0; cyc < 800 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) ? 1'b1 : (rand_start && o_busy && ($urandom_range(3) == 0));
      check({name, "_ready_only_busy"}, 32'(o_s_ready & ~o_busy), 32'd0);
      if (o_latch_wr) begin
        check({name, "_ready_in_write"}, 32'(o_s_ready), 32'd0);
        if (pulses < TOTAL) check({name, "_data"}, o_latch_data, src[pulses]);
        else                check({name, "_extra_pulse"}, 32'(pulses), 32'(TOTAL - 1));
        check({name, "_entry_idx"}, 32'(o_entry_idx), 32'(pulses / WPE));
        check({name, "_word_idx"}, 32'(o_word_idx), 32'(pulses % WPE));
        if (pulses > 0) begin
          if (exact) check({name, "_spacing"}, 32'(cyc - last_pulse), 32'(2 + cur_gap));
          else       check({name, "_min_spacing"}, 32'(cyc - last_pulse >= cur_gap + 1), 32'd1);
        end
        last_pulse = cyc;
        pulses++;
      end
      if (o_done) begin
        check({name, "_done_not_aborted"}, 32'(abort_sent), 32'd0);
        check({name, "_done_pulses"}, 32'(pulses), 32'(TOTAL));
        check({name, "_consumed"}, 32'(idx), 32'(TOTAL));
        if (exact) check({name, "_done_latency"}, 32'(cyc - last_pulse), 32'(1 + cur_gap));
        fin = 1'b1;
      end
      if (o_aborted) begin
        check({name, "_abort_latency"}, 32'(cyc), 32'(abort_cyc + 1));
        check({name, "_abort_busy"}, 32'(o_busy), 32'd0);
        check({name, "_abort_pulses"}, 32'(pulses), 32'(abort_after));
        fin = 1'b1;
      end
      abort = 1'b0;
      if (abort_after > 0 && !abort_sent && pulses == abort_after && cyc == last_pulse + 1) begin
        abort      = 1'b1;
        abort_sent = 1'b1;
        abort_cyc  = cyc;
      end
      s_valid = (idx < TOTAL) && ($urandom_range(99) < valid_pct);
      s_data  = s_valid ? src[idx] : $urandom;
      if (s_valid && o_s_ready) idx++;
    end
    if (!fin) check({name, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    check({name, "_idle_after"}, 32'(o_busy), 32'd0);
    $display("[TB] %s: sequence finished", name);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0;
    cur_gap = 1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 32'(o_busy), 32'd0);

    // Default gap, s_valid held high, words 0x11..0x16
    for (int i = 0; i < TOTAL; i++) src[i] = 32'h11 + 32'(i);
    run_seq("gap1_full_rate", 100, 0, 1'b1, 1'b0);

    // WR_GAP=0 instance, strobes every 2nd cycle
    sel = 1'b1; cur_gap = 0;
    @(negedge clk);
    run_seq("gap0_full_rate", 100, 0, 1'b1, 1'b0);

    // Sparse random source, random words, on both gap settings
    for (int r = 0; r < 2; r++) begin
      sel = r[0]; cur_gap = r[0] ? 0 : 1;
      @(negedge clk);
      for (int i = 0; i < TOTAL; i++) src[i] = $urandom;
      run_seq("sparse_valid", 25, 0, 1'b0, 1'b0);
    end

    // Abort in GAP after the 4th word, then a clean reload from entry 0 word 0
    sel = 1'b0; cur_gap = 1;
    @(negedge clk);
    for (int i = 0; i < TOTAL; i++) src[i] = $urandom;
    run_seq("abort_in_gap", 100, 4, 1'b1, 1'b0);
    for (int i = 0; i < TOTAL; i++) src[i] = $urandom;
    run_seq("reload_after_abort", 100, 0, 1'b1, 1'b0);

    // start pulses while busy must not disturb the sequence
    for (int i = 0; i < TOTAL; i++) src[i] = $urandom;
    run_seq("start_while_busy", 60, 0, 1'b0, 1'b1);

    // start together with abort in IDLE: stay idle, no aborted pulse
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(o_busy), 32'd0);
    check("start_abort_aborted", 32'(o_aborted), 32'd0);
    @(negedge clk);
    check("start_abort_busy2", 32'(o_busy), 32'd0);
    check("start_abort_aborted2", 32'(o_aborted), 32'd0);
    $display("[TB] start_abort_idle: done");

    // Asynchronous reset in the middle of WRITE
    begin
      bit seen = 1'b0;
      for (int i = 0; i < TOTAL; i++) src[i] = 32'hA0 + 32'(i);
      start = 1'b1; s_valid = 1'b1; s_data = src[0];
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (o_latch_wr) seen = 1'b1;
      end
      check("rst_saw_write", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("rst_release_busy", 32'(o_busy), 32'd0);
        check("rst_release_aborted", 32'(o_aborted), 32'd0);
      end
      s_valid = 1'b0;
      $display("[TB] reset_mid_write: done");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
